// File: rtl/etapa_wb_banco_if.sv
// rtl/etapa_wb_banco_if.sv - MEM/WB, decode read-port and trace signals of the write-back stage
interface etapa_wb_banco_if #(
  parameter int ANCHO      = 32,
  parameter int DIR        = 5,
  parameter int ANCHO_CONT = 16
);
  logic [ANCHO-1:0]      EnDatoMem;
  logic [ANCHO-1:0]      EnResALU;
  logic [DIR-1:0]        EnDirW;
  logic [1:0]            EnWB;
  logic [DIR-1:0]        EnDirA;
  logic [DIR-1:0]        EnDirB;
  logic [ANCHO-1:0]      SalDatoA;
  logic [ANCHO-1:0]      SalDatoB;
  logic [ANCHO-1:0]      SalDatoWB;
  logic [DIR-1:0]        SalUltDir;
  logic [ANCHO-1:0]      SalUltDato;
  logic [ANCHO_CONT-1:0] ContEscr;

  modport master (
    output EnDatoMem, EnResALU, EnDirW, EnWB, EnDirA, EnDirB,
    input  SalDatoA, SalDatoB, SalDatoWB, SalUltDir, SalUltDato, ContEscr
  );

  modport slave (
    input  EnDatoMem, EnResALU, EnDirW, EnWB, EnDirA, EnDirB,
    output SalDatoA, SalDatoB, SalDatoWB, SalUltDir, SalUltDato, ContEscr
  );
endinterface

// File: rtl/etapa_wb_banco.sv
// rtl/etapa_wb_banco.sv - write-back mux, register bank with bypassed read ports, commit trace
module etapa_wb_banco #(
  parameter int ANCHO      = 32,
  parameter int DIR        = 5,
  parameter int ANCHO_CONT = 16
) (
  input logic               clk,
  input logic               rst,
  etapa_wb_banco_if.slave   bus
);
  localparam int PROF = 2 ** DIR;

  logic [ANCHO-1:0]      banco [PROF];
  logic [ANCHO-1:0]      dato_wb;
  logic                  we;
  logic [DIR-1:0]        ult_dir;
  logic [ANCHO-1:0]      ult_dato;
  logic [ANCHO_CONT-1:0] cont;
  logic [ANCHO-1:0]      dato_a;
  logic [ANCHO-1:0]      dato_b;

  assign dato_wb = bus.EnWB[0] ? bus.EnDatoMem : bus.EnResALU;

  // Gating with rst also kills the bypass path while reset is held.
  assign we = bus.EnWB[1] && (bus.EnDirW != '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PROF; i++) begin
        banco[i] <= '0;
      end
      ult_dir  <= '0;
      ult_dato <= '0;
      cont     <= '0;
    end else if (we) begin
      banco[bus.EnDirW] <= dato_wb;
      ult_dir           <= bus.EnDirW;
      ult_dato          <= dato_wb;
      cont              <= cont + 1'b1;
    end
  end

  always_comb begin
    dato_a = banco[bus.EnDirA];
    if (bus.EnDirA == '0) begin
      dato_a = '0;
    end else if (we && (bus.EnDirW == bus.EnDirA)) begin
      dato_a = dato_wb;
    end
  end

  always_comb begin
    dato_b = banco[bus.EnDirB];
    if (bus.EnDirB == '0) begin
      dato_b = '0;
    end else if (we && (bus.EnDirW == bus.EnDirB)) begin
      dato_b = dato_wb;
    end
  end

  assign bus.SalDatoA   = dato_a;
  assign bus.SalDatoB   = dato_b;
  assign bus.SalDatoWB  = dato_wb;
  assign bus.SalUltDir  = ult_dir;
  assign bus.SalUltDato = ult_dato;
  assign bus.ContEscr   = cont;
endmodule

// File: tb/tb_etapa_wb_banco.sv
// tb/tb_etapa_wb_banco.sv - directed and randomized checks of etapa_wb_banco against a bank model
module tb_etapa_wb_banco;
  logic clk;
  logic rst;

  etapa_wb_banco_if #(.ANCHO(32), .DIR(5), .ANCHO_CONT(16)) b ();
  etapa_wb_banco_if #(.ANCHO(32), .DIR(5), .ANCHO_CONT(4))  b4 ();

  etapa_wb_banco #(.ANCHO(32), .DIR(5), .ANCHO_CONT(16)) dut (
    .clk(clk), .rst(rst), .bus(b.slave)
  );
  etapa_wb_banco #(.ANCHO(32), .DIR(5), .ANCHO_CONT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  int          cnt;
  logic [4:0]  m_dir;
  logic [31:0] m_dato;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    cnt    = 0;
    m_dir  = 5'd0;
    m_dato = 32'h0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we_m,
                                           input logic [4:0] dw, input logic [31:0] v);
    if (a == 5'd0) return 32'h0;
    if (we_m && dw == a) return v;
    return regs[a];
  endfunction

  task automatic step(input string tag, input logic [1:0] wb, input logic [4:0] dw,
                      input logic [4:0] da, input logic [4:0] db,
                      input logic [31:0] mem, input logic [31:0] alu);
    logic [31:0] v;
    logic        we_m;
    @(negedge clk);
    b.EnWB = wb; b.EnDirW = dw; b.EnDirA = da; b.EnDirB = db;
    b.EnDatoMem = mem; b.EnResALU = alu;
    #1;
    v    = wb[0] ? mem : alu;
    we_m = wb[1] && (dw != 5'd0);
    chk({tag, "_wb"}, b.SalDatoWB, v);
    chk({tag, "_rd_a"}, b.SalDatoA, exp_read(da, we_m, dw, v));
    chk({tag, "_rd_b"}, b.SalDatoB, exp_read(db, we_m, dw, v));
    @(posedge clk);
    #1;
    if (we_m) begin
      regs[dw] = v;
      cnt      = cnt + 1;
      m_dir    = dw;
      m_dato   = v;
    end
    chk({tag, "_cont"}, {16'h0, b.ContEscr}, cnt & 32'hFFFF);
    chk({tag, "_ult_dir"}, {27'h0, b.SalUltDir}, {27'h0, m_dir});
    chk({tag, "_ult_dato"}, b.SalUltDato, m_dato);
  endtask

  initial begin
    int cnt4;
    logic [31:0] last4;
    logic [31:0] r;

    rst = 1'b1;
    b.EnWB = 2'b00; b.EnDirW = 5'd0; b.EnDirA = 5'd0; b.EnDirB = 5'd0;
    b.EnDatoMem = 32'h0; b.EnResALU = 32'h0;
    b4.EnWB = 2'b00; b4.EnDirW = 5'd0; b4.EnDirA = 5'd0; b4.EnDirB = 5'd0;
    b4.EnDatoMem = 32'h0; b4.EnResALU = 32'h0;
    model_clear();
    #12;
    chk("rst_cont", {16'h0, b.ContEscr}, 32'h0);
    chk("rst_ult_dir", {27'h0, b.SalUltDir}, 32'h0);
    chk("rst_ult_dato", b.SalUltDato, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step("t2", 2'b10, 5'd5, 5'd0, 5'd0, 32'h0, 32'h1234_5678);
    step("t2r", 2'b00, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0);
    step("t3", 2'b11, 5'd9, 5'd9, 5'd5, 32'hDEAD_BEEF, 32'h1);
    step("t3r", 2'b00, 5'd0, 5'd9, 5'd2, 32'h0, 32'h0);
    step("t4", 2'b10, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    step("t5old", 2'b10, 5'd7, 5'd7, 5'd7, 32'h0, 32'h1111_2222);
    step("t5pre", 2'b01, 5'd7, 5'd7, 5'd7, 32'hA5A5_A5A5, 32'h0);
    step("t5byp", 2'b10, 5'd7, 5'd7, 5'd7, 32'h0, 32'hA5A5_A5A5);
    step("t5post", 2'b00, 5'd7, 5'd7, 5'd7, 32'h0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      step("rnd", r[1:0] | {($urandom_range(0, 3) != 0), 1'b0},
           (r[2] ? 5'($urandom_range(1, 4)) : 5'($urandom)),
           (r[3] ? 5'($urandom_range(0, 4)) : 5'($urandom)),
           (r[4] ? 5'($urandom_range(0, 4)) : 5'($urandom)),
           $urandom, $urandom);
    end

    // Async reset mid-cycle with a write pending: nothing may leak through.
    @(negedge clk);
    b.EnWB = 2'b10; b.EnDirW = 5'd5; b.EnResALU = 32'hCAFE_F00D;
    b.EnDirA = 5'd5; b.EnDirB = 5'd9;
    #2;
    rst = 1'b1;
    #1;
    chk("t1_rd_a", b.SalDatoA, 32'h0);
    chk("t1_rd_b", b.SalDatoB, 32'h0);
    chk("t1_cont", {16'h0, b.ContEscr}, 32'h0);
    chk("t1_ult_dir", {27'h0, b.SalUltDir}, 32'h0);
    chk("t1_ult_dato", b.SalUltDato, 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    chk("t1_edge_cont", {16'h0, b.ContEscr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    b.EnWB = 2'b00;
    step("t1after", 2'b00, 5'd0, 5'd5, 5'd9, 32'h0, 32'h0);
    step("t1first", 2'b10, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0BAD_0001);

    cnt4 = 0;
    last4 = 32'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      last4 = $urandom;
      b4.EnWB = 2'b10; b4.EnDirW = 5'd3; b4.EnResALU = last4; b4.EnDirA = 5'd3;
      @(posedge clk);
      #1;
      cnt4 = (cnt4 + 1) % 16;
      chk("t6_cont", {28'h0, b4.ContEscr}, cnt4);
    end
    @(negedge clk);
    b4.EnWB = 2'b00;
    #1;
    chk("t6_reg3", b4.SalDatoA, last4);
    chk("t6_wrap", {28'h0, b4.ContEscr}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
